// File: rtl/musa_mem_pkg.sv
// rtl/musa_mem_pkg.sv - shared types and defaults for the MUSA data memory arbiter
//
// Purpose : requester owner encoding, arbiter state enum and default
//           memory geometry shared by data_memory_arbiter and arb_rvalid_pipe.
// Ports   : none (package)

package musa_mem_pkg;

  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_ADDR_WIDTH = 8;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE_OWN = 2'd1,
    HOST_OWN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_rvalid_pipe.sv
// rtl/arb_rvalid_pipe.sv - read-return tag pipe matching the memory read latency
//
// Purpose : shifts a {valid, owner} tag through LATENCY stages so the tag
//           leaves the pipe in the same cycle the memory presents the data.
// Ports   : clk      - clock
//           rst_n    - asynchronous active-low clear (drops in-flight tags)
//           push_i   - a read was granted this cycle
//           owner_i  - requester that issued the read
//           valid_o  - tag at the end of the pipe is valid
//           owner_o  - owner of that tag

module arb_rvalid_pipe #(
  parameter int LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic owner_i,
  output logic valid_o,
  output logic owner_o
);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] own_q, own_d;

  // Stage 0 takes the new tag; works unchanged for LATENCY == 1.
  always_comb begin
    vld_d = (vld_q << 1) | LATENCY'(push_i);
    own_d = (own_q << 1) | LATENCY'(owner_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  assign valid_o = vld_q[LATENCY-1];
  assign owner_o = own_q[LATENCY-1];

endmodule

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - round-robin bounded-burst arbiter for the shared data memory
//
// Purpose : shares the single-port data memory between the core load/store
//           path and the host/debug port. Grants are combinational; the
//           owner may keep the port for MAX_BURST grants while the other
//           side waits, then ownership flips.
// Ports   : clk, rst_n                       - clock, async active-low reset
//           core_req/we/addr/wdata           - core request channel
//           core_gnt/rvalid/rdata            - core grant and read return
//           host_req/we/addr/wdata           - host request channel
//           host_gnt/rvalid/rdata            - host grant and read return
//           mem_address/mem_data/mem_wren    - drive to data_memory
//           mem_q                            - data_memory read data

module data_memory_arbiter
  import musa_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_BURST   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] burst_q, burst_d;
  owner_e        last_q, last_d;

  logic pipe_push;
  logic pipe_owner_in;
  logic pipe_valid;
  logic pipe_owner;

  // Grant decision. Grants are held off while reset is asserted so the
  // memory sees no write and the requesters see no accept.
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (rst_n) begin
      if (core_req && !host_req) begin
        core_gnt = 1'b1;
      end else if (host_req && !core_req) begin
        host_gnt = 1'b1;
      end else if (core_req && host_req) begin
        unique case (state_q)
          CORE_OWN: begin
            if (burst_q < BURST_MAX) core_gnt = 1'b1;
            else                     host_gnt = 1'b1;
          end
          HOST_OWN: begin
            if (burst_q < BURST_MAX) host_gnt = 1'b1;
            else                     core_gnt = 1'b1;
          end
          default: begin
            // From IDLE a tie goes to whoever did not own the port last.
            if (last_q == OWN_HOST) core_gnt = 1'b1;
            else                    host_gnt = 1'b1;
          end
        endcase
      end
    end
  end

  // Next state: extend the burst for the current owner, restart it on a
  // change of owner, fall back to IDLE when nobody is granted.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    last_d  = last_q;
    if (core_gnt) begin
      if (state_q == CORE_OWN) begin
        if (burst_q != BURST_MAX) burst_d = burst_q + CW'(1);
      end else begin
        state_d = CORE_OWN;
        burst_d = CW'(1);
        last_d  = OWN_CORE;
      end
    end else if (host_gnt) begin
      if (state_q == HOST_OWN) begin
        if (burst_q != BURST_MAX) burst_d = burst_q + CW'(1);
      end else begin
        state_d = HOST_OWN;
        burst_d = CW'(1);
        last_d  = OWN_HOST;
      end
    end else begin
      state_d = IDLE;
      burst_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      burst_q <= '0;
      last_q  <= OWN_HOST;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  // Memory drive follows the granted requester; quiet bus otherwise.
  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (core_gnt) begin
      mem_address = core_addr;
      mem_data    = core_wdata;
      mem_wren    = core_we;
    end else if (host_gnt) begin
      mem_address = host_addr;
      mem_data    = host_wdata;
      mem_wren    = host_we;
    end
  end

  assign pipe_push     = (core_gnt && !core_we) || (host_gnt && !host_we);
  assign pipe_owner_in = host_gnt ? OWN_HOST : OWN_CORE;

  arb_rvalid_pipe #(
    .LATENCY (MEM_LATENCY)
  ) u_rvalid_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (pipe_push),
    .owner_i (pipe_owner_in),
    .valid_o (pipe_valid),
    .owner_o (pipe_owner)
  );

  assign core_rvalid = pipe_valid && (pipe_owner == OWN_CORE);
  assign host_rvalid = pipe_valid && (pipe_owner == OWN_HOST);

  // Read data is shared; each side qualifies it with its own rvalid.
  assign core_rdata = mem_q;
  assign host_rdata = mem_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - self-checking bench for data_memory_arbiter at read latency 1 and 3

module tb_data_memory_arbiter;

  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        core_req, core_we, host_req, host_we;
  logic [7:0]  core_addr, host_addr;
  logic [31:0] core_wdata, host_wdata;

  logic        core_gnt_w    [2];
  logic        core_rvalid_w [2];
  logic [31:0] core_rdata_w  [2];
  logic        host_gnt_w    [2];
  logic        host_rvalid_w [2];
  logic [31:0] host_rdata_w  [2];
  logic [7:0]  mem_address_w [2];
  logic [31:0] mem_data_w    [2];
  logic        mem_wren_w    [2];
  logic [31:0] mem_q_w       [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int L = (k == 0) ? 1 : 3;

    data_memory_arbiter #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (8),
      .MEM_LATENCY (L),
      .MAX_BURST   (MAXB)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .core_req    (core_req),
      .core_we     (core_we),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .core_gnt    (core_gnt_w[k]),
      .core_rvalid (core_rvalid_w[k]),
      .core_rdata  (core_rdata_w[k]),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_gnt    (host_gnt_w[k]),
      .host_rvalid (host_rvalid_w[k]),
      .host_rdata  (host_rdata_w[k]),
      .mem_address (mem_address_w[k]),
      .mem_data    (mem_data_w[k]),
      .mem_wren    (mem_wren_w[k]),
      .mem_q       (mem_q_w[k])
    );

    // Synchronous single-port memory with L-cycle read latency.
    logic [31:0] mem [256];
    logic [31:0] qp  [L];
    always @(posedge clk) begin
      if (mem_wren_w[k]) mem[mem_address_w[k]] <= mem_data_w[k];
      qp[0] <= mem[mem_address_w[k]];
      for (int i = 1; i < L; i++) qp[i] <= qp[i-1];
    end
    assign mem_q_w[k] = qp[L-1];
  end

  // Reference model: grant history per cycle and a word-level memory image.
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          rst_floor = 0;
  int          streak_owner = 0;
  int          streak_len = 0;
  int          last_granted = 1;
  int          obs_g;
  bit          hist_v [4096];
  int          hist_o [4096];
  logic [31:0] hist_d [4096];
  logic [31:0] ref_mem [256];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s lat%0d cyc%0d observed=0x%08h expected=0x%08h", tag, lat_of(k), cyc, obs, exp);
    end
  endtask

  task automatic do_cycle(input logic creq, input logic cwe, input logic [7:0] caddr, input logic [31:0] cwd,
                          input logic hreq, input logic hwe, input logic [7:0] haddr, input logic [31:0] hwd);
    int          g;
    logic [7:0]  ea;
    logic [31:0] ed;
    logic        ew;
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
    if (creq && !hreq)       g = 0;
    else if (hreq && !creq)  g = 1;
    else if (creq && hreq) begin
      if (streak_len == 0)         g = 1 - last_granted;
      else if (streak_len < MAXB)  g = streak_owner;
      else                         g = 1 - streak_owner;
    end else                       g = -1;
    ea = (g == 0) ? caddr : (g == 1) ? haddr : 8'h00;
    ed = (g == 0) ? cwd   : (g == 1) ? hwd   : 32'h0;
    ew = (g == 0) ? cwe   : (g == 1) ? hwe   : 1'b0;
    #4;
    obs_g = core_gnt_w[0] ? 0 : (host_gnt_w[0] ? 1 : 3);
    for (int k = 0; k < 2; k++) begin
      int idx;
      bit ev;
      ev  = 1'b0;
      idx = cyc - lat_of(k);
      if (idx >= rst_floor) ev = hist_v[idx];
      check("core_gnt", k, 32'(core_gnt_w[k]), 32'(g == 0));
      check("host_gnt", k, 32'(host_gnt_w[k]), 32'(g == 1));
      check("mem_address", k, 32'(mem_address_w[k]), 32'(ea));
      check("mem_data", k, mem_data_w[k], ed);
      check("mem_wren", k, 32'(mem_wren_w[k]), 32'(ew));
      check("core_rvalid", k, 32'(core_rvalid_w[k]), 32'(ev && hist_o[idx] == 0));
      check("host_rvalid", k, 32'(host_rvalid_w[k]), 32'(ev && hist_o[idx] == 1));
      check("core_rdata_q", k, core_rdata_w[k], mem_q_w[k]);
      check("host_rdata_q", k, host_rdata_w[k], mem_q_w[k]);
      if (ev) begin
        if (hist_o[idx] == 0) check("core_rdata", k, core_rdata_w[k], hist_d[idx]);
        else                  check("host_rdata", k, host_rdata_w[k], hist_d[idx]);
      end
    end
    @(posedge clk);
    hist_v[cyc] = 1'b0;
    if (g >= 0) begin
      hist_v[cyc] = !ew;
      hist_o[cyc] = g;
      hist_d[cyc] = ref_mem[ea];
      if (ew) ref_mem[ea] = ed;
      if (streak_len > 0 && streak_owner == g) streak_len++;
      else begin
        streak_owner = g;
        streak_len   = 1;
      end
      last_granted = g;
    end else begin
      streak_len = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0);
  endtask

  task automatic do_reset(input logic hreq);
    rst_n    = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = 8'h0; core_wdata = 32'h0;
    host_req = hreq; host_we = 1'b0; host_addr = 8'h10; host_wdata = 32'h0;
    #4;
    for (int k = 0; k < 2; k++) begin
      check("rst_core_gnt", k, 32'(core_gnt_w[k]), 32'h0);
      check("rst_host_gnt", k, 32'(host_gnt_w[k]), 32'h0);
      check("rst_core_rvalid", k, 32'(core_rvalid_w[k]), 32'h0);
      check("rst_host_rvalid", k, 32'(host_rvalid_w[k]), 32'h0);
      check("rst_mem_wren", k, 32'(mem_wren_w[k]), 32'h0);
      check("rst_mem_address", k, 32'(mem_address_w[k]), 32'h0);
      check("rst_mem_data", k, mem_data_w[k], 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    hist_v[cyc]  = 1'b0;
    cyc++;
    rst_floor    = cyc;
    streak_len   = 0;
    last_granted = 1;
    host_req     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = 8'h0; core_wdata = 32'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h0; host_wdata = 32'h0;
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // Host preload then core read of the same word.
    do_cycle(0, 0, 8'h00, 32'h0, 1, 1, 8'h10, 32'hDEADBEEF);
    do_cycle(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0);
    idle(4);

    // Both requesting from reset: bursts of four, alternating owners.
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      do_cycle(1, 1, 8'(8'h40 + i), $urandom, 1, 1, 8'(8'h60 + i), $urandom);
      check("burst_pattern", 0, 32'(obs_g), 32'(((i / MAXB) % 2 == 0) ? 0 : 1));
    end
    idle(2);

    // Host write then immediate core read of the same address.
    do_cycle(0, 0, 8'h00, 32'h0, 1, 1, 8'h05, 32'h12345678);
    do_cycle(1, 0, 8'h05, 32'h0, 0, 0, 8'h00, 32'h0);
    idle(4);

    // Preload 1..4, then four back-to-back core reads.
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 8'h0, 32'h0, 1, 1, 8'(i), 32'(i + 1));
    for (int i = 0; i < 4; i++) do_cycle(1, 0, 8'(i), 32'h0, 0, 0, 8'h0, 32'h0);
    idle(4);

    // Reset while a host read is in flight; host_req held high during reset.
    do_cycle(0, 0, 8'h00, 32'h0, 1, 0, 8'h10, 32'h0);
    do_reset(1'b1);
    idle(4);
    do_cycle(1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0);
    check("tie_after_reset", 0, 32'(obs_g), 32'h0);
    idle(4);

    // Alternating single requests with idle gaps.
    for (int i = 0; i < 3; i++) begin
      do_cycle(1, 0, 8'(i), 32'h0, 0, 0, 8'h0, 32'h0);
      check("alt_core_gnt", 0, 32'(obs_g), 32'h0);
      idle(1);
      do_cycle(0, 0, 8'h0, 32'h0, 1, 0, 8'h05, 32'h0);
      check("alt_host_gnt", 0, 32'(obs_g), 32'h1);
      idle(1);
    end

    // Random traffic over a small address window.
    for (int i = 0; i < 16; i++) do_cycle(0, 0, 8'h0, 32'h0, 1, 1, 8'(i), $urandom);
    for (int i = 0; i < 400; i++) begin
      do_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
               $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
Shares the single-port 256x32 synchronous data memory between the MUSA core load/store path and a host/debug port (memory preload, result dump, DMA).
- Sits between the core datapath (ALU address / register data / mux_data return) and data_memory.
- Round-robin arbitration with a bounded burst, so the core is never starved and neither is the host.
- Tracks in-flight reads and returns data with a per-requester valid strobe.

Parameters:
DATA_WIDTH, 32, memory word width
ADDR_WIDTH, 8, memory word address width
MEM_LATENCY, 1, cycles from address presentation to valid mem_q (>=1)
MAX_BURST, 4, max consecutive grants to one requester while the other is requesting (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
core_req  input  1  core access request, held until granted
core_we  input  1  1=write, 0=read
core_addr  input  ADDR_WIDTH  core word address
core_wdata  input  DATA_WIDTH  core write data
core_gnt  output  1  core access accepted this cycle
core_rvalid  output  1  core read data valid
core_rdata  output  DATA_WIDTH  core read data
host_req  input  1  host access request
host_we  input  1  1=write, 0=read
host_addr  input  ADDR_WIDTH  host word address
host_wdata  input  DATA_WIDTH  host write data
host_gnt  output  1  host access accepted this cycle
host_rvalid  output  1  host read data valid
host_rdata  output  DATA_WIDTH  host read data
mem_address  output  ADDR_WIDTH  to data_memory address
mem_data  output  DATA_WIDTH  to data_memory data
mem_wren  output  1  to data_memory wren
mem_q  input  DATA_WIDTH  from data_memory q

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last_owner=HOST (core wins the first tie), burst_cnt=0, read pipeline cleared. Outputs: core_rvalid=host_rvalid=0, core_gnt=host_gnt=0, mem_wren=0. mem_address and mem_data are 0 while no grant is active.
- FSM states: IDLE, CORE_OWN, HOST_OWN. Registered burst_cnt (saturating at MAX_BURST) and last_owner.
- Grant is combinational from req inputs and registered state. At most one gnt per cycle.
  - Only one requester active: that requester is granted.
  - Both active, state X_OWN with burst_cnt<MAX_BURST: X is granted.
  - Both active, X_OWN with burst_cnt==MAX_BURST: the other requester is granted.
  - Both active in IDLE: the requester that is not last_owner is granted.
- Next state:
  - Grant to the current owner: burst_cnt+1 (saturating).
  - Grant to a new owner: state=new owner, burst_cnt=1, last_owner=new owner.
  - No request: IDLE, burst_cnt=0, last_owner unchanged.
- Memory drive: mem_address, mem_data and mem_wren follow the granted requester combinationally. mem_wren=gnt&we. No grant: mem_wren=0.
- Read return:
  - A granted read pushes its owner tag into a MEM_LATENCY-deep shift pipe.
  - Exactly MEM_LATENCY cycles later the matching rvalid pulses for 1 cycle.
  - core_rdata and host_rdata both equal mem_q at all times; they are qualified only by rvalid.
- Writes produce no rvalid. Back-to-back reads are fully pipelined, 1 grant per cycle.
- A requester may drop req without being granted; no state is affected other than arbitration.
- Read-after-write to the same address in consecutive grants returns the new data (memory ordering, single port).
- Reset asserted mid-flight: pending reads are discarded and no rvalid is emitted after release. Requesters must re-issue.
- req, we, addr and wdata are sampled only in the granted cycle.

Decomposition:
- Shared package musa_mem_pkg:
  - owner encoding (OWN_CORE=0, OWN_HOST=1)
  - arbiter state enum (IDLE/CORE_OWN/HOST_OWN)
  - default widths DATA_WIDTH=32, ADDR_WIDTH=8
- One sub-module: arb_rvalid_pipe, the MEM_LATENCY-deep {valid,owner} shift register with async clear.

Test Plan:
1. Reset, then core_req=1 read addr 0x10 after a host preload of 0x10=0xDEADBEEF -> core_gnt in the request cycle; core_rvalid 1 cycle later with core_rdata=0xDEADBEEF; host_rvalid stays 0.
2. Both req held continuously from reset, MAX_BURST=4 -> core_gnt cycles 0-3, host_gnt 4-7, core_gnt 8-11; never both gnt in one cycle.
3. Host write 0x05=0x12345678, next cycle core read 0x05 -> mem_wren=1 for exactly one cycle; core_rdata=0x12345678 on core_rvalid.
4. Core issues 4 back-to-back reads 0x00-0x03 (preloaded 1,2,3,4) -> 4 consecutive core_rvalid pulses returning 1,2,3,4 in order, MEM_LATENCY=1 and MEM_LATENCY=3.
5. rst_n pulsed low for 1 cycle while a host read is in flight (MEM_LATENCY=3) -> all outputs 0 immediately; no host_rvalid after release; the first tie afterwards goes to core.
6. Alternating single requests (core, idle, host, idle) -> each granted in its own request cycle; burst_cnt returns to 0 in IDLE; no starvation or latency penalty.
